// File: rtl/logic_eqn_tt_checker.sv
// logic_eqn_tt_checker
//   On-chip self-test harness for a gate-level implementation of
//   Y = (P + Q').(R' + D). It steps through all 16 input vectors, holds each
//   one for SETTLE_CYCLES cycles plus one sampling cycle, and compares the
//   returned response against EXP_TT. It reports pass/fail, the mismatch
//   count and the lowest failing vector.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   start_i          begin a run (accepted in IDLE only)
//   p_o/q_o/r_o/d_o  stimulus vector bits 3..0
//   y_i              response from the equation under test
//   busy_o           high from run start through the DONE cycle
//   done_o           one-cycle end-of-run pulse
//   pass_o           last run had no mismatches (held until next start)
//   err_cnt_o        mismatch count, 0..16
//   first_err_vld_o  at least one mismatch recorded
//   first_err_idx_o  index of the lowest mismatching vector
//
// State   | meaning
// IDLE    | vector parked at 0, results held, waiting for start
// WAIT    | current vector settling for SETTLE_CYCLES cycles
// SAMPLE  | one cycle; y_i compared at the closing edge
// DONE    | one-cycle done pulse, pass latched on entry

module logic_eqn_tt_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_TT        = 16'hBB0B
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       p_o,
  output logic       q_o,
  output logic       r_o,
  output logic       d_o,
  input  logic       y_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_cnt_o,
  output logic       first_err_vld_o,
  output logic [3:0] first_err_idx_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic [3:0] settle_cnt;
  logic [4:0] err_cnt;
  logic [4:0] err_cnt_nxt;
  logic       first_err_vld;
  logic [3:0] first_err_idx;
  logic       pass;
  logic       mismatch;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_WAIT;
      ST_WAIT:   if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec == 4'd15) ? ST_DONE : ST_WAIT;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state != ST_IDLE);
    done_o = (state == ST_DONE);
  end

  assign mismatch    = (state == ST_SAMPLE) && (y_i != EXP_TT[vec]);
  // Count including the current sample, so pass reflects the final vector.
  assign err_cnt_nxt = err_cnt + {4'd0, mismatch};

  // Datapath: stimulus vector, settle timer and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec           <= 4'd0;
      settle_cnt    <= 4'd0;
      err_cnt       <= 5'd0;
      first_err_vld <= 1'b0;
      first_err_idx <= 4'd0;
      pass          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            vec           <= 4'd0;
            settle_cnt    <= 4'd0;
            err_cnt       <= 5'd0;
            first_err_vld <= 1'b0;
            first_err_idx <= 4'd0;
            pass          <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          err_cnt <= err_cnt_nxt;
          if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= vec;
          end
          if (vec == 4'd15) begin
            pass <= (err_cnt_nxt == 5'd0);
          end else begin
            vec        <= vec + 4'd1;
            settle_cnt <= 4'd0;
          end
        end
        ST_DONE: begin
          vec <= 4'd0;
        end
        default: begin
          vec <= 4'd0;
        end
      endcase
    end
  end

  assign p_o             = vec[3];
  assign q_o             = vec[2];
  assign r_o             = vec[1];
  assign d_o             = vec[0];
  assign err_cnt_o       = err_cnt;
  assign first_err_vld_o = first_err_vld;
  assign first_err_idx_o = first_err_idx;
  assign pass_o          = pass;

endmodule

// File: tb/tb_logic_eqn_tt_checker.sv
module tb_logic_eqn_tt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1;
  logic p0, q0, r0, d0, y0, busy0, done0, pass0, fv0;
  logic [4:0] ec0;
  logic [3:0] fi0;
  logic p1, q1, r1, d1, y1, busy1, done1, pass1, fv1;
  logic [4:0] ec1;
  logic [3:0] fi1;
  logic [15:0] mask0, mask1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic_eqn_tt_checker dut (
    .clk_i(clk), .rst_i(rst), .start_i(start0),
    .p_o(p0), .q_o(q0), .r_o(r0), .d_o(d0), .y_i(y0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(ec0),
    .first_err_vld_o(fv0), .first_err_idx_o(fi0)
  );

  logic_eqn_tt_checker #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .p_o(p1), .q_o(q1), .r_o(r1), .d_o(d1), .y_i(y1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(ec1),
    .first_err_vld_o(fv1), .first_err_idx_o(fi1)
  );

  // Reference equation Y = (P + Q').(R' + D), index n = {p,q,r,d}
  function automatic logic eqn(input logic [3:0] n);
    return (n[3] | ~n[2]) & (~n[1] | n[0]);
  endfunction

  function automatic logic [15:0] golden_tt();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = eqn(4'(i));
    return t;
  endfunction

  // Equation under test with a per-vector fault mask (1 = flip the response)
  always_comb y0 = eqn({p0, q0, r0, d0}) ^ mask0[{p0, q0, r0, d0}];
  always_comb y1 = eqn({p1, q1, r1, d1}) ^ mask1[{p1, q1, r1, d1}];

  // Observation mux so one run task serves both instances
  int sel = 0;
  logic [3:0] o_vec;
  logic o_busy, o_done, o_pass, o_fv;
  logic [4:0] o_ec;
  logic [3:0] o_fi;
  always_comb begin
    if (sel == 1) begin
      o_vec = {p1, q1, r1, d1}; o_busy = busy1; o_done = done1;
      o_pass = pass1; o_ec = ec1; o_fv = fv1; o_fi = fi1;
    end else begin
      o_vec = {p0, q0, r0, d0}; o_busy = busy0; o_done = done0;
      o_pass = pass0; o_ec = ec0; o_fv = fv0; o_fi = fi0;
    end
  end

  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v; else start0 = v;
  endtask

  // One full run; pokes are cycle offsets after the accepting edge where a
  // spurious start is presented (must be ignored).
  task automatic run_check(input string name, input int s, input logic [15:0] mask,
                           input int poke_a, input int poke_b);
    int per, last, exp_err, exp_first;
    logic [3:0] exp_vec;
    logic exp_done;
    sel = s;
    if (s == 1) mask1 = mask; else mask0 = mask;
    per       = (s == 1) ? 2 : 3;
    last      = 16 * per;
    exp_err   = $countones(mask);
    exp_first = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) exp_first = i;

    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    for (int c = 0; c <= last; c++) begin
      exp_done = (c == last);
      exp_vec  = (c == last) ? 4'd15 : 4'(c / per);
      tests_run++;
      if ({o_busy, o_done, o_vec} !== {1'b1, exp_done, exp_vec}) begin
        tests_failed++;
        $display("FAIL %s run cyc%0d busy/done/vec got %b/%b/%0d want 1/%b/%0d",
                 name, c, o_busy, o_done, o_vec, exp_done, exp_vec);
      end
      if (c == 0) begin
        tests_run++;
        if ({o_pass, o_ec, o_fv, o_fi} !== 11'd0) begin
          tests_failed++;
          $display("FAIL %s start_clear pass/err/vld/idx got %b/%0d/%b/%0d want 0/0/0/0",
                   name, o_pass, o_ec, o_fv, o_fi);
        end
      end
      set_start(s, (c == poke_a) || (c == poke_b));
      @(negedge clk);
    end
    set_start(s, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({o_busy, o_done, o_vec} !== 6'd0) begin
        tests_failed++;
        $display("FAIL %s idle%0d busy/done/vec got %b/%b/%0d want 0/0/0",
                 name, k, o_busy, o_done, o_vec);
      end
      tests_run++;
      if (o_ec !== 5'(exp_err) || o_fv !== (mask != 16'd0) || o_fi !== 4'(exp_first) ||
          o_pass !== (mask == 16'd0)) begin
        tests_failed++;
        $display("FAIL %s result%0d err/vld/idx/pass got %0d/%b/%0d/%b want %0d/%b/%0d/%b",
                 name, k, o_ec, o_fv, o_fi, o_pass, exp_err, (mask != 16'd0),
                 exp_first, (mask == 16'd0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b1;  // reset must win over start
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({p0, q0, r0, d0, busy0, done0, pass0, ec0, fv0, fi0} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset dut outputs got %b want all 0",
               {p0, q0, r0, d0, busy0, done0, pass0, ec0, fv0, fi0});
    end
    tests_run++;
    if ({p1, q1, r1, d1, busy1, done1, pass1, ec1, fv1, fi1} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset dut_s1 outputs got %b want all 0",
               {p1, q1, r1, d1, busy1, done1, pass1, ec1, fv1, fi1});
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_faults();
    logic [15:0] g = golden_tt();
    run_check("golden",     0, 16'h0000, -1, -1);
    run_check("stuck_at_0", 0, g,        -1, -1);
    run_check("stuck_at_1", 0, ~g,       -1, -1);
    run_check("inverted",   0, 16'hFFFF, -1, -1);
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 16'($urandom);
      if (i == 0) m = 16'h1 << $urandom_range(15, 0);
      run_check("random", 0, m, -1, -1);
    end
    run_check("random_s1", 1, 16'($urandom), -1, -1);
  endtask

  task automatic test_timing();
    run_check("timing_s1", 1, 16'h0000, 10, 32);   // 32 = DONE cycle
    run_check("back_to_back_s2", 0, 16'h0000, 5, 48);
  endtask

  task automatic test_reset_mid_run();
    logic saw_done = 1'b0;
    mask0 = golden_tt();  // stuck-at-0 response
    sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (fv0 !== 1'b1 || busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_pre vld/busy got %b/%b want 1/1", fv0, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({p0, q0, r0, d0, busy0, done0, pass0, ec0, fv0, fi0} !== 18'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset outputs got %b want all 0",
               {p0, q0, r0, d0, busy0, done0, pass0, ec0, fv0, fi0});
    end
    for (int c = 0; c < 60; c++) begin
      if (done0 || busy0) saw_done = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_quiet busy_or_done got 1 want 0");
    end
    run_check("after_reset", 0, 16'h0000, -1, -1);
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mask0 = 16'd0;
    mask1 = 16'd0;
    test_reset();
    test_faults();
    test_timing();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
